// File: rtl/joy_event_tx.sv
// joy_event_tx: turns five active-low joystick keys into coded events.
//   Each key is synchronized and debounced. Every debounced press or release
//   fills that key's pending slot. A fixed-priority arbiter then moves pending
//   slots into a small show-ahead FIFO that feeds a valid/ready stream.
//
// Handshake: a pop happens when evt_valid and evt_ready are both high on a
// rising clk edge. evt_code is the head entry while evt_valid is high. While
// evt_valid is low, evt_code holds the last popped code (0 after reset).
//
// Optional feature: define JOY_EVENT_AUTOREPEAT_EN to add a single repeat
// timer. It issues type 10 events for the most recently pressed key. In the
// default build there is no timer and the REPEAT_* parameters are unused.
//
// Event code: [4:3] type (00 release, 01 press, 10 repeat), [2:0] key id
//   key id: 0 z, 1 up, 2 down, 3 left, 4 right.
module joy_event_tx #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_z,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [4:0] evt_code,
    output logic [4:0] keys_state,
    output logic       evt_drop
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] T_REL   = 2'b00;
    localparam logic [1:0] T_PRESS = 2'b01;
    localparam logic [1:0] T_RPT   = 2'b10;

    // Raw pins gathered so that bit index equals key id.
    logic [4:0] raw_keys;
    assign raw_keys = {key_right, key_left, key_down, key_up, key_z};

    logic [4:0] sync1_q, sync2_q;

    // Two-flop synchronizer. It resets to the released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw_keys;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce. stable_q holds the accepted pin level (1 = released).
    // ------------------------------------------------------------------
    logic [4:0]    stable_q;
    logic [CW-1:0] cnt_q [5];
    logic [4:0]    flip;
    logic [4:0]    press_edge;
    logic [4:0]    rel_edge;

    // A key flips once its new level has held for DEBOUNCE_CYCLES samples.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 5; i++) begin
            flip[i] = (sync2_q[i] != stable_q[i]) &&
                      (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    assign press_edge = flip & stable_q;
    assign rel_edge   = flip & ~stable_q;
    assign keys_state = ~stable_q;

    // Per-key hold counter and accepted level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= '1;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (flip[i]) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO occupancy and pointers.
    // ------------------------------------------------------------------
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [4:0]    last_q;
    logic          full, empty, pop;

    assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = !empty && evt_ready;
    assign evt_valid = !empty;
    assign evt_code  = empty ? last_q : mem_q[rptr_q];

    // ------------------------------------------------------------------
    // Arbiter: the lowest pending key id wins. It writes only if the FIFO
    // was not full at the start of the cycle.
    // ------------------------------------------------------------------
    logic [4:0] pend_v_q;
    logic [1:0] pend_t_q [5];
    logic [4:0] grant;
    logic       wr_en;
    logic [2:0] wr_id;
    logic [1:0] wr_type;

    // Scan from the highest id down so that the lowest pending id wins.
    always_comb begin
        grant   = '0;
        wr_en   = 1'b0;
        wr_id   = '0;
        wr_type = '0;
        if (!full) begin
            for (int i = 4; i >= 0; i--) begin
                if (pend_v_q[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    wr_en    = 1'b1;
                    wr_id    = 3'(i);
                    wr_type  = pend_t_q[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional repeat timer.
    // ------------------------------------------------------------------
    logic [4:0] rpt_fire;

`ifdef JOY_EVENT_AUTOREPEAT_EN
    logic        rpt_active_q;
    logic [2:0]  rpt_key_q;
    logic [31:0] rpt_cnt_q;
    logic [4:0]  rpt_onehot;
    logic        rpt_press_any;
    logic [2:0]  rpt_press_id;

    assign rpt_onehot = 5'b00001 << rpt_key_q;

    // Among simultaneous presses, the highest id becomes the tracked key.
    always_comb begin
        rpt_press_any = |press_edge;
        rpt_press_id  = '0;
        for (int i = 0; i < 5; i++) begin
            if (press_edge[i]) rpt_press_id = 3'(i);
        end
        rpt_fire = '0;
        if (rpt_active_q && rpt_cnt_q == '0) rpt_fire = rpt_onehot;
    end

    // Timer: load on press, reload after each expiry, stop on tracked release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_active_q <= 1'b0;
            rpt_key_q    <= '0;
            rpt_cnt_q    <= '0;
        end else if (rpt_press_any) begin
            rpt_active_q <= 1'b1;
            rpt_key_q    <= rpt_press_id;
            rpt_cnt_q    <= 32'(REPEAT_DELAY - 1);
        end else if (rpt_active_q && |(rel_edge & rpt_onehot)) begin
            rpt_active_q <= 1'b0;
        end else if (rpt_active_q) begin
            if (rpt_cnt_q == '0) rpt_cnt_q <= 32'(REPEAT_PERIOD - 1);
            else                 rpt_cnt_q <= rpt_cnt_q - 1'b1;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire          = '0;
`endif

    // ------------------------------------------------------------------
    // Pending slots. A new edge always wins. The grant clears the slot. A
    // repeat fills the slot only when it is empty.
    // ------------------------------------------------------------------
    logic drop_d, drop_q;

    assign drop_d   = |((press_edge | rel_edge) & pend_v_q & ~grant);
    assign evt_drop = drop_q;

    // Slot update and the registered overwrite pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v_q <= '0;
            for (int i = 0; i < 5; i++) pend_t_q[i] <= T_REL;
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
            for (int i = 0; i < 5; i++) begin
                if (press_edge[i] || rel_edge[i]) begin
                    pend_v_q[i] <= 1'b1;
                    pend_t_q[i] <= press_edge[i] ? T_PRESS : T_REL;
                end else if (grant[i]) begin
                    pend_v_q[i] <= 1'b0;
                end else if (rpt_fire[i] && !pend_v_q[i]) begin
                    pend_v_q[i] <= 1'b1;
                    pend_t_q[i] <= T_RPT;
                end
            end
        end
    end

    // FIFO storage. It needs no reset because count_q guards every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= {wr_type, wr_id};
    end

    // FIFO pointers, occupancy and the last popped code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
                last_q <= mem_q[rptr_q];
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: doc/joy_event_tx.md
# joy_event_tx

Debounces the five active-low joystick keys and turns each debounced press or release into a coded event on a valid/ready stream, buffered in a small FIFO. It is the event-producing end of the joystick input path. Downstream consumers, such as the LED and menu logic or the UART reporter, pop codes from it instead of sampling raw key levels.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a key must hold a new level before it is accepted (10 ms at 50 MHz). Must be ≥ 8.
- `FIFO_DEPTH`, default 4: number of event entries. Must be a power of 2, ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles from a press to the first repeat. Used only with autorepeat.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeats. Used only with autorepeat.

Ports:
- `clk` in, 1: system clock.
- `reset` in, 1: reset, asynchronous, active-low.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_z` in, 1 each: raw key pins, asynchronous, 0 = pressed.
- `evt_valid` out, 1: the FIFO head holds an event.
- `evt_ready` in, 1: consumer accepts the head event.
- `evt_code` out, 5: [4:3] type (00 release, 01 press, 10 repeat, 11 unused); [2:0] key id (0 z, 1 up, 2 down, 3 left, 4 right).
- `keys_state` out, 5: debounced levels, bit i = key id i, 1 = pressed.
- `evt_drop` out, 1: one-cycle pulse when an unqueued event is overwritten.

## Operation
**Synchronizer**
- Each key passes through a 2-flop synchronizer.
- The flops reset to 1 (released).

**Debounce (per key)**
- Counter clears whenever the synchronized level equals the stable level.
- Otherwise the counter increments.
- When the counter reaches `DEBOUNCE_CYCLES-1` and the level still differs:
  - the stable level flips,
  - the matching `keys_state` bit updates,
  - an edge fires: press on 1→0 pin level, release on 0→1.
- Any glitch shorter than `DEBOUNCE_CYCLES` produces no event.

**Pending slots**
- Each key has one pending slot holding a flag and a 2-bit type.
- An edge sets the slot.
- An edge arriving while the slot is already set overwrites it and pulses `evt_drop`.

**Arbiter**
- Each cycle, if the FIFO is not full, it writes the lowest-id pending key and clears that slot.
- At most one write per cycle; priority is z > up > down > left > right.

**FIFO**
- Show-ahead. `evt_valid` = not empty; `evt_code` = head entry.
- A pop occurs when `evt_valid` and `evt_ready` are both high.
- The full check uses the occupancy at the start of the cycle. A full FIFO accepts no write even in a pop cycle; the write lands the following cycle.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- Pop on empty is ignored.
- `evt_code` holds its last value while `evt_valid` = 0.

## Timing
- Reset values:
  - `evt_valid` = 0, `evt_code` = 0, `keys_state` = 0, `evt_drop` = 0.
  - FIFO empty, pending slots clear, counters 0.
- Reset asserted mid-operation flushes the FIFO and discards pending events. If a key is still held after reset releases, a press event follows after 2 + `DEBOUNCE_CYCLES` cycles.
- Latency, pin edge → `keys_state` change: 2 + `DEBOUNCE_CYCLES` cycles.
- Latency, `keys_state` change → `evt_valid` high with an empty FIFO and no competing pending slot: 1 cycle.
- Simultaneous edges on k keys: events enter the FIFO on k consecutive cycles in priority order, provided the FIFO is not full.
- `evt_drop` is registered and high for exactly one cycle per overwrite.

## Configuration
- `JOY_EVENT_AUTOREPEAT_EN` defined:
  - One repeat timer tracks the most recently pressed key.
  - It loads `REPEAT_DELAY` on that key's press event.
  - It reloads `REPEAT_PERIOD` after each repeat it issues.
  - On expiry it sets that key's pending slot to type 10. If the slot is already set, the repeat is skipped, with no `evt_drop` and no overwrite.
  - The timer stops on release of the tracked key.
  - A press of another key retargets the timer.
- `JOY_EVENT_AUTOREPEAT_EN` undefined:
  - No timer logic.
  - Type 10 is never emitted.
  - `REPEAT_*` parameters are ignored.

## Test plan
- `DEBOUNCE_CYCLES` = 8. `key_up` held low 20 cycles, then high → press code 01_001, later release code 00_001. `keys_state[1]` is 1 during the press, 0 after.
- `key_left` low for 5 cycles only → no event, `keys_state` stays 0, `evt_valid` stays 0.
- `key_z` and `key_right` fall in the same cycle, `evt_ready` = 1 → codes 01_000 then 01_100 on consecutive cycles.
- `evt_ready` = 0, `FIFO_DEPTH` = 4, six debounced edges applied:
  - four entries stored, the rest held pending;
  - one slot overwritten → one `evt_drop` pulse;
  - after `evt_ready` = 1, all remaining codes drain in order.
- Reset asserted while the FIFO holds 3 events and `key_down` is held → `evt_valid` drops immediately. After reset release, a single 01_010 appears after 10 + 1 cycles.
- Autorepeat, with `REPEAT_DELAY` = 40 and `REPEAT_PERIOD` = 16: `key_up` held 100 cycles → press, repeats 10_001 at +40, +56, +72, +88, then release. Without the macro → press and release only.
